// File: rtl/iq_quantizer_rs.sv
// I/Q quantizer: round-half-up (or floor), drop SHIFT LSBs, saturate to OUT_W bits, 2-stage pipe.
// Define QUANTIZER_SAT_CNT_EN to build the saturated-beat counter (satCount / satClr).
module iq_quantizer_rs #(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned SHIFT    = 8,
    parameter bit          ROUND_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*IN_W-1:0]    inData,
    input  logic                 inValid,
    output logic                 inReady,
    output logic [2*OUT_W-1:0]   outData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [1:0]           outSat,
    input  logic                 satClr,
    output logic [31:0]          satCount
);

    localparam int unsigned RW = IN_W + 1;

    localparam logic [RW-1:0] RndV =
        (ROUND_EN && SHIFT > 0) ? (RW'(1) << (SHIFT - 1)) : '0;
    localparam logic signed [RW-1:0] MaxV =
        {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [RW-1:0] MinV =
        {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic                   ce;
    logic [1:0][RW-1:0]     acc_d, acc_q;
    logic                   v1_d, v1_q;
    logic signed [RW-1:0]   shifted [2];
    logic [2*OUT_W-1:0]     out_data_d, out_data_q;
    logic [1:0]             out_sat_d, out_sat_q;
    logic                   out_valid_d, out_valid_q;

    // Stalls only when the output beat is held by the consumer; empty slots always fill.
    assign ce      = !out_valid_q || outReady;
    assign inReady = ce;

    // Stage 1: sign-extend by one bit and add the rounding offset, so the sum cannot wrap.
    always_comb begin
        acc_d = acc_q;
        v1_d  = v1_q;
        if (ce) begin
            for (int c = 0; c < 2; c++) begin
                acc_d[c] = {inData[c*IN_W + IN_W - 1], inData[c*IN_W +: IN_W]} + RndV;
            end
            v1_d = inValid;
        end
    end

    // Stage 2: arithmetic shift then clamp to the signed OUT_W range.
    always_comb begin
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        for (int c = 0; c < 2; c++) begin
            shifted[c] = $signed(acc_q[c]) >>> SHIFT;
        end
        if (ce) begin
            out_valid_d = v1_q;
            for (int c = 0; c < 2; c++) begin
                if (shifted[c] > MaxV) begin
                    out_data_d[c*OUT_W +: OUT_W] = MaxV[OUT_W-1:0];
                    out_sat_d[c]                 = 1'b1;
                end else if (shifted[c] < MinV) begin
                    out_data_d[c*OUT_W +: OUT_W] = MinV[OUT_W-1:0];
                    out_sat_d[c]                 = 1'b1;
                end else begin
                    out_data_d[c*OUT_W +: OUT_W] = shifted[c][OUT_W-1:0];
                    out_sat_d[c]                 = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            v1_q        <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            v1_q        <= v1_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign outData  = out_data_q;
    assign outSat   = out_sat_q;
    assign outValid = out_valid_q;

`ifdef QUANTIZER_SAT_CNT_EN
    logic [31:0] sat_cnt_d, sat_cnt_q;

    // Clear has priority over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (satClr) begin
            sat_cnt_d = '0;
        end else if (out_valid_q && outReady && (|out_sat_q) && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign satCount = sat_cnt_q;
`else
    logic unused_sat_clr;
    assign unused_sat_clr = satClr;
    assign satCount       = '0;
`endif

endmodule

// File: tb/tb_iq_quantizer_rs.sv
// Self-checking bench for iq_quantizer_rs: directed vectors, backpressure, async reset,
// randomized stream against an arithmetic reference model, and the optional saturation counter.
module tb_iq_quantizer_rs;

    localparam int unsigned IN_W     = 16;
    localparam int unsigned OUT_W    = 8;
    localparam int unsigned SHIFT    = 8;
    localparam bit          ROUND_EN = 1'b1;

    typedef logic [2*OUT_W+1:0] beat_t;  // {satQ, satI, Q, I}

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [2*IN_W-1:0]    inData = '0;
    logic                 inValid = 1'b0;
    logic                 inReady;
    logic [2*OUT_W-1:0]   outData;
    logic                 outValid;
    logic                 outReady = 1'b0;
    logic [1:0]           outSat;
    logic                 satClr = 1'b0;
    logic [31:0]          satCount;

    int n_vec = 0;
    int n_err = 0;

    iq_quantizer_rs #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT),
        .ROUND_EN(ROUND_EN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .inData  (inData),
        .inValid (inValid),
        .inReady (inReady),
        .outData (outData),
        .outValid(outValid),
        .outReady(outReady),
        .outSat  (outSat),
        .satClr  (satClr),
        .satCount(satCount)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic, floor via arithmetic shift of a 32-bit int, then clamp.
    function automatic logic [OUT_W:0] ref_comp(input logic [IN_W-1:0] x);
        int v, hi, lo;
        logic [OUT_W-1:0] y;
        logic s;
        v = int'($signed(x));
        if (ROUND_EN && SHIFT > 0) v = v + (1 << (SHIFT - 1));
        v  = v >>> SHIFT;
        hi = (1 << (OUT_W - 1)) - 1;
        lo = -(1 << (OUT_W - 1));
        if (v > hi) begin
            y = hi[OUT_W-1:0];
            s = 1'b1;
        end else if (v < lo) begin
            y = lo[OUT_W-1:0];
            s = 1'b1;
        end else begin
            y = v[OUT_W-1:0];
            s = 1'b0;
        end
        return {s, y};
    endfunction

    function automatic beat_t ref_beat(input logic [2*IN_W-1:0] d);
        logic [OUT_W:0] ri, rq;
        ri = ref_comp(d[IN_W-1:0]);
        rq = ref_comp(d[2*IN_W-1:IN_W]);
        return {rq[OUT_W], ri[OUT_W], rq[OUT_W-1:0], ri[OUT_W-1:0]};
    endfunction

    // Biased toward the interesting regions: near limits and exact rounding ties.
    function automatic logic [IN_W-1:0] rand_comp();
        logic [IN_W-1:0] r;
        logic [IN_W-1:0] t;
        r = IN_W'($urandom);
        case ($urandom_range(0, 4))
            0: t = 16'h7F00 | {8'h00, r[7:0]};
            1: t = 16'h8000 | {8'h00, r[7:0]};
            2: t = {r[15:8], 8'h80};
            default: t = r;
        endcase
        return t;
    endfunction

    task automatic test_reset();
        rst      = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        satClr   = 1'b0;
        inData   = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (outValid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", outValid);
        end
        n_vec++;
        if (outData !== '0) begin
            n_err++; $display("FAIL reset_data: got %h want 0000", outData);
        end
        n_vec++;
        if (outSat !== 2'b00) begin
            n_err++; $display("FAIL reset_sat: got %b want 00", outSat);
        end
        n_vec++;
        if (satCount !== 32'd0) begin
            n_err++; $display("FAIL reset_count: got %0d want 0", satCount);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (inReady !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b want 1", inReady);
        end
    endtask

    task automatic test_vectors();
        logic [2*IN_W-1:0]  vin  [5] = '{32'h0080_0180, 32'h8000_FF80, 32'h7F7F_7FFF,
                                         32'hFF7F_7F80, 32'h0000_0000};
        logic [2*OUT_W-1:0] vout [5] = '{16'h0102, 16'h8000, 16'h7F7F, 16'hFF7F, 16'h0000};
        logic [1:0]         vsat [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            outReady = 1'b1;
            inValid  = 1'b1;
            inData   = vin[k];
            @(negedge clk);
            inValid = 1'b0;
            #1;
            n_vec++;
            if (outValid !== 1'b0) begin
                n_err++; $display("FAIL vec%0d_early: outValid=%b want 0", k, outValid);
            end
            @(negedge clk);
            #1;
            n_vec++;
            if (outValid !== 1'b1 || outData !== vout[k] || outSat !== vsat[k]) begin
                n_err++;
                $display("FAIL vec%0d: valid=%b data=%h sat=%b want 1 %h %b",
                         k, outValid, outData, outSat, vout[k], vsat[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t exp_q[$];
        beat_t e;
        int sent = 0;
        int got = 0;
        logic prev_stall = 1'b0;
        logic [2*OUT_W-1:0] prev_data = '0;
        logic [1:0] prev_sat = '0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            outReady = !(cyc >= 3 && cyc <= 6);
            inValid  = (sent < 8);
            inData   = {rand_comp(), rand_comp()};
            #1;
            if (prev_stall) begin
                n_vec++;
                if (outValid !== 1'b1 || outData !== prev_data || outSat !== prev_sat) begin
                    n_err++;
                    $display("FAIL bp_stable: valid=%b data=%h sat=%b want 1 %h %b",
                             outValid, outData, outSat, prev_data, prev_sat);
                end
            end
            if (cyc == 4) begin
                n_vec++;
                if (inReady !== 1'b0) begin
                    n_err++; $display("FAIL bp_full_ready: got %b want 0", inReady);
                end
            end
            if (inValid && inReady) begin
                exp_q.push_back(ref_beat(inData));
                sent++;
            end
            if (outValid && outReady) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL bp_extra: beat %h with nothing expected", outData);
                end else begin
                    e = exp_q.pop_front();
                    if ({outSat, outData} !== e) begin
                        n_err++;
                        $display("FAIL bp_beat%0d: got %h want %h", got, {outSat, outData}, e);
                    end
                end
                got++;
            end
            prev_stall = outValid && !outReady;
            prev_data  = outData;
            prev_sat   = outSat;
        end
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b1;
        n_vec++;
        if (got != 8 || exp_q.size() != 0) begin
            n_err++; $display("FAIL bp_count: got %0d beats, %0d pending, want 8 and 0",
                              got, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        outReady = 1'b1;
        inValid  = 1'b1;
        inData   = 32'h1234_5678;
        @(negedge clk);
        inData = 32'h7FFF_7FFF;
        @(negedge clk);
        inValid = 1'b0;
        #1;
        n_vec++;
        if (outValid !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_inflight: outValid=%b want 1", outValid);
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (outValid !== 1'b0 || outData !== '0 || outSat !== 2'b00 || satCount !== 32'd0) begin
            n_err++;
            $display("FAIL rst_mid_async: valid=%b data=%h sat=%b cnt=%0d want 0 0 0 0",
                     outValid, outData, outSat, satCount);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (outValid !== 1'b0) begin
                n_err++; $display("FAIL rst_mid_ghost%0d: outValid=%b want 0", k, outValid);
            end
        end
        @(negedge clk);
        inValid = 1'b1;
        inData  = 32'h0080_0180;
        #1;
        n_vec++;
        if (inReady !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_ready: got %b want 1", inReady);
        end
        @(negedge clk);
        inValid = 1'b0;
        #1;
        n_vec++;
        if (outValid !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_lat1: outValid=%b want 0", outValid);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (outValid !== 1'b1 || {outSat, outData} !== {2'b00, 16'h0102}) begin
            n_err++; $display("FAIL rst_mid_lat2: valid=%b beat=%h want 1 00102",
                              outValid, {outSat, outData});
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (outValid !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_dup: outValid=%b want 0", outValid);
        end
    endtask

    task automatic test_random();
        beat_t exp_q[$];
        beat_t e;
        int exp_cnt = 0;
        logic prev_stall = 1'b0;
        logic [2*OUT_W-1:0] prev_data = '0;
        logic [1:0] prev_sat = '0;
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b1;
        satClr   = 1'b1;
        @(negedge clk);
        satClr = 1'b0;
        for (int cyc = 0; cyc < 330; cyc++) begin
            @(negedge clk);
            if (cyc < 300) begin
                inValid  = ($urandom_range(0, 9) < 7);
                outReady = ($urandom_range(0, 9) < 6);
            end else begin
                inValid  = 1'b0;
                outReady = 1'b1;
            end
            inData = {rand_comp(), rand_comp()};
            #1;
            if (prev_stall) begin
                n_vec++;
                if (outValid !== 1'b1 || outData !== prev_data || outSat !== prev_sat) begin
                    n_err++;
                    $display("FAIL rnd_stable@%0d: valid=%b data=%h sat=%b want 1 %h %b",
                             cyc, outValid, outData, outSat, prev_data, prev_sat);
                end
            end
            if (inValid && inReady) exp_q.push_back(ref_beat(inData));
            if (outValid && outReady) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra@%0d: beat %h unexpected", cyc, outData);
                end else begin
                    e = exp_q.pop_front();
                    if ({outSat, outData} !== e) begin
                        n_err++;
                        $display("FAIL rnd_beat@%0d: got %h want %h", cyc, {outSat, outData}, e);
                    end
                end
                if (|outSat) exp_cnt++;
            end
            prev_stall = outValid && !outReady;
            prev_data  = outData;
            prev_sat   = outSat;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL rnd_drain: %0d beats never emerged, want 0", exp_q.size());
        end
`ifndef QUANTIZER_SAT_CNT_EN
        exp_cnt = 0;
`endif
        n_vec++;
        if (satCount !== 32'(exp_cnt)) begin
            n_err++; $display("FAIL rnd_count: got %0d want %0d", satCount, exp_cnt);
        end
    endtask

    task automatic test_sat_count();
        int want;
`ifdef QUANTIZER_SAT_CNT_EN
        want = 3;
`else
        want = 0;
`endif
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b1;
        satClr   = 1'b1;
        @(negedge clk);
        satClr = 1'b0;
        #1;
        n_vec++;
        if (satCount !== 32'd0) begin
            n_err++; $display("FAIL cnt_clear: got %0d want 0", satCount);
        end
        for (int k = 0; k < 5; k++) begin
            inValid = 1'b1;
            inData  = (k < 3) ? 32'h0000_7FFF : 32'h0100_0100;
            @(negedge clk);
        end
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (satCount !== 32'(want)) begin
            n_err++; $display("FAIL cnt_three: got %0d want %0d", satCount, want);
        end
`ifdef QUANTIZER_SAT_CNT_EN
        @(negedge clk);
        inValid = 1'b1;
        inData  = 32'h0000_7FFF;
        @(negedge clk);
        inValid = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (outValid !== 1'b1 || outSat !== 2'b01) begin
            n_err++; $display("FAIL cnt_setup: valid=%b sat=%b want 1 01", outValid, outSat);
        end
        satClr = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (satCount !== 32'd0) begin
            n_err++; $display("FAIL cnt_clr_wins: got %0d want 0", satCount);
        end
        satClr = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (satCount !== 32'd0) begin
            n_err++; $display("FAIL cnt_after_clr: got %0d want 0", satCount);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_midstream();
        test_random();
        test_sat_count();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iq_quantizer_rs.md
# iq_quantizer_rs

Parametrised I/Q quantizer with rounding, saturation and ready/valid flow control. It sits between the scaling stage and the packer, and reduces each signed I and Q component from IN_W to OUT_W bits. It drops SHIFT LSBs with optional round-half-up, and clamps out-of-range results to the signed limits. A 2-stage pipeline provides full backpressure, and the block flags saturation per beat.

## Interface
- IN_W, 16: input width per component, signed two's complement.
- OUT_W, 8: output width per component.
- SHIFT, 8: number of LSBs dropped. Constraint: 0 ≤ SHIFT, SHIFT + OUT_W ≤ IN_W.
- ROUND_EN, 1: 1 = round half up; 0 = truncate (floor).
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inData  in  2*IN_W  {Q, I}; I in [IN_W-1:0], Q in [2*IN_W-1:IN_W].
- inValid  in  1  input beat valid.
- inReady  out  1  input beat accepted when inValid && inReady.
- outData  out  2*OUT_W  {Q, I}, same packing as inData.
- outValid  out  1  output beat valid.
- outReady  in  1  downstream accepts the beat.
- outSat  out  2  {satQ, satI}; a bit is 1 when that component was clamped in the current outData.
- satClr  in  1  synchronous clear of satCount (macro only).
- satCount  out  32  count of beats with any outSat bit set (macro only).

## Operation
- Per component x (IN_W signed):
  - Stage 1: r = x + (ROUND_EN && SHIFT>0 ? 2^(SHIFT-1) : 0), computed in IN_W+1 bits with sign extension, so r never wraps.
  - Stage 2: s = r >>> SHIFT (arithmetic shift).
  - Stage 2 saturation: if s > 2^(OUT_W-1)-1, the output is 2^(OUT_W-1)-1 with the sat bit set. If s < -2^(OUT_W-1), the output is -2^(OUT_W-1) with the sat bit set. Otherwise the output is s[OUT_W-1:0] with the sat bit clear.
- I and Q are processed identically and independently. All channels share the pipeline.
- Round half up ties go toward +inf; -0.5 LSB rounds to 0.
- Pipeline enable is ce = !outValid || outReady, and inReady = ce.
  - When ce is 1: stage 1 loads inData and v1 <= inValid && inReady. Stage 2 loads stage 1, and outValid <= v1.
  - When ce is 0: both stages hold. outData, outSat and outValid stay stable while outValid && !outReady (AXI-Stream rule).
- Bubbles collapse: a valid beat in stage 1 advances into an empty stage 2 even if outReady is low.
- Reset, at any time, including mid-stream:
  - Outputs: outValid=0, outData=0, outSat=0, satCount=0.
  - Internal: v1=0, so in-flight beats are discarded.
  - inReady goes to 1 once reset is released.

## Timing
- Latency: 2 cycles from an accepted input beat to outValid, when there is no backpressure.
- Throughput: 1 beat per cycle while outReady=1.
- inReady is combinational from outValid and outReady, with no combinational path from inValid.
- outData, outSat and outValid are registered.
- Simultaneous outReady=1 with a valid stage 1: the output beat is consumed and the next beat is loaded in the same cycle.

## Configuration
- QUANTIZER_SAT_CNT_EN
- Defined:
  - satCount increments by 1 on each output handshake (outValid && outReady) where outSat != 0.
  - satCount saturates at 2^32-1.
  - satClr=1 loads 0 on the next edge; clear wins over a simultaneous increment.
- Undefined:
  - satClr is ignored, satCount is tied to 0, and no counter logic is present.
  - outSat is still generated.

## Test plan
- Default params, I=0x0180, Q=0x0080, outReady=1 -> after 2 cycles outData={0x01,0x02}, outSat=0.
- I=0xFF80 (-128), Q=0x8000 -> I=0x00, Q=0x80 (-128), outSat=0. With ROUND_EN=0 -> I=0xFF, Q=0x80.
- I=0x7FFF, Q=0x7F7F -> I=0x7F with satI=1; Q: 0x7F7F+0x80=0x7FFF, >>8 gives 0x7F, satQ=0 -> outSat=2'b01.
- Stream 8 beats, hold outReady=0 for cycles 3-6 -> no beat lost or duplicated, outData stable while stalled, inReady=0 while both stages are full, output order preserved.
- Assert rst low with 2 beats in flight -> outValid=0 immediately (async). After release, the first new beat appears 2 cycles after acceptance and the old beats never appear.
- Macro defined: 3 saturating beats plus 2 clean beats -> satCount=3. Pulse satClr together with a saturating handshake -> satCount=0.
